// File: rtl/axis_block_packer.sv
// Packs an 8-bit AXI-Stream into 128-bit blocks with optional PKCS#7 padding. The block appears one cycle after the closing byte.
// Input backpressure: s_axis_tready is low while a block is held for output. It does not depend on m_axis_tready.
module axis_block_packer #(
    parameter int CNT_W                = 16,
    parameter bit BYTE_ORDER_MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             PadEn,
    input  logic             Flush,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [127:0]     m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [4:0]       Fill,
    output logic             Busy,
    output logic [CNT_W-1:0] BlockCnt
);

    typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

    state_t             state_q;
    logic [15:0][7:0]   acc_q, acc_d;
    logic [4:0]         fill_q, fill_d;
    logic               pad_pending_q;
    logic [127:0]       tdata_q, blk_d;
    logic               tvalid_q, tlast_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               s_acc, flush_eff, full_d, last_byte_d, tlast_close_d, close_d, pend_d;
    logic [7:0]         pad_byte_d;
    logic [7:0]         slot_d [16];

    assign s_axis_tready = (state_q == FILL) && En && !Rst;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign Fill          = fill_q;
    assign Busy          = (state_q != FILL) || (fill_q != 5'd0);
    assign BlockCnt      = cnt_q;

    // A byte and a Flush in the same cycle: the byte is counted first, then the flush sees the new count.
    always_comb begin
        s_acc  = s_axis_tvalid && s_axis_tready;
        acc_d  = acc_q;
        fill_d = fill_q;
        if (s_acc) begin
            acc_d[fill_q[3:0]] = s_axis_tdata;
            fill_d             = fill_q + 5'd1;
        end
        flush_eff     = (state_q == FILL) && En && Flush && ((fill_d != 5'd0) || PadEn);
        full_d        = (fill_d == 5'd16);
        last_byte_d   = s_acc && s_axis_tlast;
        tlast_close_d = last_byte_d || flush_eff;
        close_d       = (s_acc && full_d) || tlast_close_d;
        pend_d        = PadEn && full_d && last_byte_d;
        pad_byte_d    = PadEn ? {3'b000, 5'd16 - fill_d} : 8'h00;
        blk_d         = '0;
        for (int i = 0; i < 16; i++) begin
            slot_d[i] = (5'(i) < fill_d) ? acc_d[i] : pad_byte_d;
            if (BYTE_ORDER_MSB_FIRST)
                blk_d[127 - 8*i -: 8] = slot_d[i];
            else
                blk_d[8*i +: 8] = slot_d[i];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= FILL;
            acc_q         <= '0;
            fill_q        <= '0;
            pad_pending_q <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    acc_q  <= acc_d;
                    fill_q <= fill_d;
                    if (close_d) begin
                        tdata_q       <= blk_d;
                        tlast_q       <= tlast_close_d && !pend_d;
                        pad_pending_q <= pend_d;
                        tvalid_q      <= 1'b1;
                        fill_q        <= 5'd0;
                        state_q       <= EMIT;
                    end
                end
                EMIT: begin
                    if (tvalid_q && m_axis_tready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (pad_pending_q) begin
                            tdata_q       <= {16{8'h10}};
                            tlast_q       <= 1'b1;
                            pad_pending_q <= 1'b0;
                            state_q       <= EMIT_PAD;
                        end else begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= FILL;
                        end
                    end
                end
                EMIT_PAD: begin
                    if (tvalid_q && m_axis_tready) begin
                        cnt_q    <= cnt_q + 1'b1;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        state_q  <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: doc/axis_block_packer.md
Name: axis_block_packer

Overview:
- Assembles an 8-bit AXI-Stream byte stream into 128-bit AES plaintext blocks.
- Feeds the 128-bit s_axis input of the AES cipher stage, which today receives blocks only from the EPR register path.
- Optional PKCS#7 padding closes partial or terminal blocks on s_axis tlast or on an explicit Flush pulse.
- Single clock domain; no internal FIFO beyond one output block register.

Parameters:
- CNT_W, 16, width of the emitted-block counter.
- BYTE_ORDER_MSB_FIRST, 1, 1: first byte lands in tdata[127:120]; 0: first byte lands in tdata[7:0].

Ports:
- Clk  input  1  clock, all logic rising-edge.
- Rst  input  1  asynchronous active-high reset.
- En  input  1  0: s_axis.tready forced 0 and Flush ignored; state is held, nothing is discarded.
- PadEn  input  1  1: PKCS#7 padding; 0: zero padding, and no empty pad block.
- Flush  input  1  single-cycle request to close the current partial block.
- s_axis  taxi_axis_if.snk  DATA_W=8  tdata, tvalid, tready, tlast.
- m_axis  taxi_axis_if.src  DATA_W=128  tdata, tvalid, tready, tlast.
- Fill  output  5  bytes currently held in the accumulator, 0..16.
- Busy  output  1  high when the state is not FILL, or when Fill is nonzero.
- BlockCnt  output  CNT_W  blocks accepted downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: m_axis.tvalid=0, m_axis.tlast=0, m_axis.tdata=0, s_axis.tready=0, Fill=0, BlockCnt=0, Busy=0, state=FILL, pad_pending=0.
- Rst is asynchronous; asserting it mid-block or mid-emit discards all partial data with no output.
- States: FILL, EMIT, EMIT_PAD.
- FILL:
  - s_axis.tready = En.
  - Each accepted byte (tvalid & tready) is written to slot Fill, then Fill increments.
- FILL exits to EMIT when any of these occurs:
  - the 16th byte is accepted;
  - a byte is accepted with tlast=1;
  - Flush=1 with En=1 and Fill>0.
- On the EMIT transition, the output register loads in the same edge:
  - The n collected bytes go into their slots.
  - With PadEn=1, each remaining slot gets the value 16-n.
  - With PadEn=0, each remaining slot gets 0x00.
  - Fill is cleared to 0.
  - m_axis.tvalid rises on the next cycle, giving 1 cycle latency from the closing byte.
- m_axis.tlast is 1 when the block was closed by tlast or Flush, and 0 when closed by a plain 16th byte.
- Byte plus Flush in the same cycle: the byte is counted first, and the flush then applies to the updated count.
- Flush with Fill=0 in FILL is ignored when PadEn=0. When PadEn=1 it emits a full pad block: 16 bytes of 0x10, with tlast=1.
- Terminal full block with PadEn=1: if the 16th byte is accepted with tlast=1, set pad_pending=1. The data block is emitted with tlast=0, followed by a block of 16×0x10 with tlast=1.
- Terminal full block with PadEn=0: the data block is emitted with tlast=1 and no extra block follows.
- EMIT:
  - s_axis.tready=0 and Flush is ignored.
  - m_axis.tdata and tlast stay stable while tvalid=1 and tready=0.
  - On tvalid & tready, BlockCnt increments.
  - Next state is EMIT_PAD if pad_pending=1, otherwise FILL.
- EMIT_PAD:
  - On entry, the output register loads 16×0x10 with tlast=1 and pad_pending clears.
  - Behaves like EMIT, then returns to FILL.
- PadEn and BYTE_ORDER are sampled at block close. Changing PadEn mid-block affects only blocks not yet closed.
- No combinational path exists from m_axis.tready to s_axis.tready. Throughput is at most 16 bytes per 17 cycles with tready held high.

Test Plan:
- 16 bytes 0x00..0x0F streamed back-to-back, tlast=0, PadEn=0, m_axis.tready=1:
  - One block 0x000102...0E0F (MSB-first) with tlast=0 is emitted one cycle after the last byte.
  - BlockCnt=1.
  - s_axis.tready is low exactly during the EMIT cycle.
- 5 bytes 0xA0..0xA4, tlast on the 5th, PadEn=1:
  - Block A0A1A2A3A4 followed by eleven 0x0B bytes, tlast=1.
- 16 bytes with tlast on the 16th, PadEn=1:
  - Data block with tlast=0, then a block of 16×0x10 with tlast=1.
  - BlockCnt=2.
- 3 bytes then a Flush pulse, PadEn=0, m_axis.tready held 0 for 10 cycles:
  - Block of the 3 bytes followed by 13×0x00, tlast=1.
  - tdata is stable for all 10 stall cycles.
  - s_axis.tready stays 0 throughout; Fill=0.
- Same-cycle cases:
  - Flush coincident with the 7th byte, PadEn=1: the block carries 7 bytes plus nine 0x09 pad bytes.
  - Flush with Fill=0: PadEn=0 gives no output; PadEn=1 gives a full 0x10 block.
- Reset and wrap cases:
  - Rst asserted after 9 bytes: Fill=0 and no m_axis.tvalid occurs; a following 16-byte stream produces a clean block.
  - With CNT_W=2, 5 blocks leave BlockCnt=1.
